// File: rtl/freq_meter.sv
// freq_meter: measures a slow square wave that is asynchronous to clkin.
// After a start pulse it waits for an arming rising edge. It then counts
// rising edges over a window of GATE_CYCLES clkin cycles, and records the
// clkin period between the last two counted edges.
//
// Ports:
//   clkin   system clock
//   rst     asynchronous reset, active low
//   en      1 = counters and FSM advance, 0 = everything frozen
//   start   measurement request, sampled only in IDLE
//   sig_in  measured signal, asynchronous to clkin
//   busy    high in ARM, MEASURE and DONE
//   done    one-cycle strobe while the new results are presented
//   freq    rising edges counted in the gate window
//   period  clkin cycles between the last two counted edges (0 if no edge)
//   ovf     a counter saturated during the last measurement
//   nosig   the last measurement timed out in ARM without seeing an edge
//
// state   | meaning
// IDLE    | waiting for start
// ARM     | waiting for the arming edge, timeout after GATE_CYCLES
// MEASURE | gate window open, counting edges and the period
// DONE    | results presented for one cycle, done high
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 32,
  parameter int PER_W       = 32
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq,
  output logic [PER_W-1:0] period,
  output logic             ovf,
  output logic             nosig
);

  localparam int GATE_W = $clog2(GATE_CYCLES) + 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [PER_W-1:0]  PER_MAX   = '1;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  state_t state_q, state_d;

  logic s1, s2, s3;
  logic rise;

  logic [GATE_W-1:0] gate_q, gate_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic [PER_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic              ovfw_q, ovfw_d;

  logic [CNT_W-1:0]  freq_d;
  logic [PER_W-1:0]  period_d;
  logic              ovf_d, nosig_d;

  // Values after this MEASURE cycle. They are used both for the working
  // registers and for the outputs on the last window cycle, so a rise on
  // that cycle still reaches the result.
  logic [CNT_W-1:0]  edge_n;
  logic [PER_W-1:0]  per_n;
  logic [PER_W-1:0]  last_n;
  logic              ovf_n;

  // Two-flop synchronizer plus an edge flop. Every edge sees the same
  // latency, so edge-to-edge periods are exact. It runs regardless of en.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_comb begin
    state_d  = state_q;
    gate_d   = gate_q;
    per_d    = per_q;
    last_d   = last_q;
    edge_d   = edge_q;
    ovfw_d   = ovfw_q;
    freq_d   = freq;
    period_d = period;
    ovf_d    = ovf;
    nosig_d  = nosig;
    edge_n   = edge_q;
    per_n    = per_q;
    last_n   = last_q;
    ovf_n    = ovfw_q;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            gate_d  = '0;
            per_d   = '0;
            last_d  = '0;
            edge_d  = '0;
            ovfw_d  = 1'b0;
            state_d = ARM;
          end
        end

        ARM: begin
          if (rise) begin
            // The arming edge only opens the window and is not counted.
            gate_d  = '0;
            per_d   = '0;
            edge_d  = '0;
            state_d = MEASURE;
          end else if (gate_q == GATE_LAST) begin
            freq_d   = '0;
            period_d = '0;
            ovf_d    = 1'b0;
            nosig_d  = 1'b1;
            state_d  = DONE;
          end else begin
            gate_d = gate_q + GATE_W'(1);
          end
        end

        MEASURE: begin
          if (rise) begin
            if (edge_q == CNT_MAX) ovf_n = 1'b1;
            else                   edge_n = edge_q + CNT_W'(1);
            if (per_q == PER_MAX) begin
              ovf_n  = 1'b1;
              last_n = PER_MAX;
            end else begin
              last_n = per_q + PER_W'(1);
            end
            per_n = '0;
          end else begin
            if (per_q == PER_MAX) ovf_n = 1'b1;
            else                  per_n = per_q + PER_W'(1);
          end

          edge_d = edge_n;
          per_d  = per_n;
          last_d = last_n;
          ovfw_d = ovf_n;

          if (gate_q == GATE_LAST) begin
            freq_d   = edge_n;
            period_d = (edge_n != '0) ? last_n : '0;
            ovf_d    = ovf_n;
            nosig_d  = 1'b0;
            state_d  = DONE;
          end else begin
            gate_d = gate_q + GATE_W'(1);
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gate_q  <= '0;
      per_q   <= '0;
      last_q  <= '0;
      edge_q  <= '0;
      ovfw_q  <= 1'b0;
      freq    <= '0;
      period  <= '0;
      ovf     <= 1'b0;
      nosig   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      per_q   <= per_d;
      last_q  <= last_d;
      edge_q  <= edge_d;
      ovfw_q  <= ovfw_d;
      freq    <= freq_d;
      period  <= period_d;
      ovf     <= ovf_d;
      nosig   <= nosig_d;
    end
  end

  // Results are loaded on the edge entering DONE, so the strobe and the new
  // values appear together. Gating with en keeps done low while frozen.
  assign busy = (state_q != IDLE);
  assign done = en && (state_q == DONE);

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, start, sig;
  logic start_s, sig_c, sig_p;

  logic       busy, done, ovf, nosig;
  logic [7:0] freq, period;
  logic       busy_c, done_c, ovf_c, nosig_c;
  logic [2:0] freq_c;
  logic [7:0] period_c;
  logic       busy_p, done_p, ovf_p, nosig_p;
  logic [7:0] freq_p;
  logic [3:0] period_p;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .PER_W(8)) dut (
    .clkin(clk), .rst(rst), .en(en), .start(start), .sig_in(sig),
    .busy(busy), .done(done), .freq(freq), .period(period),
    .ovf(ovf), .nosig(nosig));

  freq_meter #(.GATE_CYCLES(100), .CNT_W(3), .PER_W(8)) dut_c (
    .clkin(clk), .rst(rst), .en(en), .start(start_s), .sig_in(sig_c),
    .busy(busy_c), .done(done_c), .freq(freq_c), .period(period_c),
    .ovf(ovf_c), .nosig(nosig_c));

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .PER_W(4)) dut_p (
    .clkin(clk), .rst(rst), .en(en), .start(start_s), .sig_in(sig_p),
    .busy(busy_p), .done(done_p), .freq(freq_p), .period(period_p),
    .ovf(ovf_p), .nosig(nosig_p));

  int n_cmp = 0;
  int n_bad = 0;
  int tcount = 0;
  bit gen_run = 1'b0;
  int ph = 9;
  int ph_c = 0;
  int ph_p = 0;

  typedef struct {
    string name;
    bit    gen_on;
    int    pause_len;
    bit    extra_start;
    int    exp_lat;
    int    exp_freq;
    int    exp_period;
    bit    exp_ovf;
    bit    exp_nosig;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, tcount);
    end
  endtask

  // One clock: everything is driven and sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
    tcount++;
    if (gen_run) begin
      ph  = (ph == 9) ? 0 : ph + 1;
      sig = (ph < 5);
    end
    ph_c  = (ph_c + 1) % 4;
    sig_c = (ph_c < 2);
    ph_p  = (ph_p + 1) % 40;
    sig_p = (ph_p < 20);
  endtask

  task automatic settle();
    gen_run = 1'b0;
    ph      = 9;
    sig     = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int s, t_ref, t_done, t1, t2, n_done;
    bit got_c, got_p;
    int fc, pc, oc, nc, fp, pp, op, np;

    // name, gen_on, pause_len, extra_start, latency, freq, period, ovf, nosig
    vecs[0] = '{"meas10",   1'b1, 0,  1'b0, 103, 10, 10, 1'b0, 1'b0};
    vecs[1] = '{"nosig",    1'b0, 0,  1'b0, 101, 0,  0,  1'b0, 1'b1};
    vecs[2] = '{"pause20",  1'b1, 20, 1'b0, 123, 10, 10, 1'b0, 1'b0};
    vecs[3] = '{"busystrt", 1'b1, 0,  1'b1, 103, 10, 10, 1'b0, 1'b0};

    rst = 1'b0; en = 1'b1; start = 1'b0; sig = 1'b0; start_s = 1'b0;
    sig_c = 1'b0; sig_p = 1'b0;
    repeat (3) tick();
    chk("rst0_busy",   int'(busy), 0);
    chk("rst0_done",   int'(done), 0);
    chk("rst0_freq",   int'(freq), 0);
    chk("rst0_period", int'(period), 0);
    chk("rst0_flags",  int'({ovf, nosig}), 0);
    rst = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 4; i++) begin
      settle();
      s = tcount;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({vecs[i].name, "_busy_start"}, int'(busy), 1);
      if (vecs[i].gen_on) begin
        repeat (4) tick();
        gen_run = 1'b1;
        tick();
        t_ref = tcount;
      end else begin
        t_ref = s;
      end
      t_done = -1;
      while (t_done < 0 && tcount < t_ref + 400) begin
        if (vecs[i].pause_len > 0 && tcount == t_ref + 45) begin
          en = 1'b0; gen_run = 1'b0;
        end
        if (vecs[i].pause_len > 0 && tcount == t_ref + 45 + vecs[i].pause_len) begin
          en = 1'b1; gen_run = 1'b1;
        end
        start = vecs[i].extra_start && (tcount == t_ref + 30);
        tick();
        if (done) t_done = tcount;
      end
      start = 1'b0;
      en = 1'b1;
      chk({vecs[i].name, "_latency"}, t_done - t_ref, vecs[i].exp_lat);
      chk({vecs[i].name, "_freq"},    int'(freq),   vecs[i].exp_freq);
      chk({vecs[i].name, "_period"},  int'(period), vecs[i].exp_period);
      chk({vecs[i].name, "_ovf"},     int'(ovf),    int'(vecs[i].exp_ovf));
      chk({vecs[i].name, "_nosig"},   int'(nosig),  int'(vecs[i].exp_nosig));
      chk({vecs[i].name, "_busy_done"}, int'(busy), 1);
      tick();
      chk({vecs[i].name, "_done_1cyc"}, int'(done), 0);
      chk({vecs[i].name, "_busy_fall"}, int'(busy), 0);

      // Mid-sim reset right after the first good measurement.
      if (i == 0) begin
        gen_run = 1'b1;
        repeat (7) tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_freq",   int'(freq), 0);
        chk("arst_period", int'(period), 0);
        chk("arst_busy",   int'(busy), 0);
        chk("arst_done",   int'(done), 0);
        repeat (3) tick();
        rst = 1'b1;
        n_done = 0;
        repeat (30) begin
          tick();
          if (done) n_done++;
        end
        chk("arst_no_done", n_done, 0);
        chk("arst_freq_hold", int'(freq), 0);
      end
    end

    // Reset in the middle of MEASURE aborts without a done.
    settle();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    gen_run = 1'b1;
    repeat (30) tick();
    chk("abort_busy_before", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    repeat (3) tick();
    rst = 1'b1;
    n_done = 0;
    repeat (150) begin
      tick();
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_idle", int'(busy), 0);

    // start while en=0 is ignored.
    settle();
    en = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    chk("en0_start_ignored", int'(busy), 0);
    start = 1'b0;
    en = 1'b1;
    tick();

    // start held high: back-to-back timeouts with one IDLE cycle between.
    settle();
    s = tcount;
    start = 1'b1;
    t1 = -1;
    t2 = -1;
    while (t2 < 0 && tcount < s + 400) begin
      tick();
      if (done && t1 < 0) begin
        t1 = tcount;
        tick();
        chk("held_idle_gap", int'(busy), 0);
      end else if (done) begin
        t2 = tcount;
      end
    end
    start = 1'b0;
    chk("held_first_done", t1 - s, 101);
    chk("held_second_done", t2 - t1, 102);
    chk("held_nosig", int'(nosig), 1);
    repeat (3) tick();

    // Saturation on narrow counters.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    got_c = 1'b0; got_p = 1'b0;
    fc = -1; pc = -1; oc = -1; nc = -1; fp = -1; pp = -1; op = -1; np = -1;
    for (int k = 0; k < 300 && !(got_c && got_p); k++) begin
      tick();
      if (done_c) begin
        got_c = 1'b1;
        fc = int'(freq_c); pc = int'(period_c); oc = int'(ovf_c); nc = int'(nosig_c);
      end
      if (done_p) begin
        got_p = 1'b1;
        fp = int'(freq_p); pp = int'(period_p); op = int'(ovf_p); np = int'(nosig_p);
      end
    end
    chk("cnt_sat_done",   int'(got_c), 1);
    chk("cnt_sat_freq",   fc, 7);
    chk("cnt_sat_ovf",    oc, 1);
    chk("cnt_sat_period", pc, 4);
    chk("cnt_sat_nosig",  nc, 0);
    chk("per_sat_done",   int'(got_p), 1);
    chk("per_sat_period", pp, 15);
    chk("per_sat_ovf",    op, 1);
    chk("per_sat_freq",   fp, 2);
    chk("per_sat_nosig",  np, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures a slow, asynchronous square-wave input, such as a divided clock or external toggle, in clkin cycles.
- Counts the input's rising edges over a fixed gate window to give frequency.
- Reports the period between its last two rising edges.
- Measurement is started by a pulse; results are held and flagged with a one-cycle done strobe.
- Used by self-test and debug logic to confirm that generated clocks run at their programmed rate.

Parameters:
GATE_CYCLES, 50000000, gate window length in clkin cycles (1 s at 50 MHz); also the ARM timeout
CNT_W, 32, width of edge-count result
PER_W, 32, width of period result

Ports:
clkin  in  1  system clock, 50 MHz
rst  in  1  reset, asynchronous, active-low (0 = reset)
en  in  1  1 = counters advance; 0 = all counters and FSM frozen
start  in  1  request a measurement; sampled only in IDLE
sig_in  in  1  measured signal, asynchronous to clkin
busy  out  1  1 in ARM, MEASURE, DONE
done  out  1  one-cycle pulse when results update
freq  out  CNT_W  rising edges counted in gate window
period  out  PER_W  clkin cycles between last two counted edges
ovf  out  1  a counter saturated during the last measurement
nosig  out  1  last measurement timed out with no edge

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0: busy, done, freq, period, ovf, nosig.
  - Synchronizer flops and internal counters are 0.
  - A reset during any state aborts the measurement; no done is issued.
- Input conditioning:
  - sig_in passes through 2 flops (s1, s2), then a third flop (s3).
  - rise = s2 & ~s3.
  - Fixed 3-cycle detection latency, identical for every edge, so period is exact.
  - Synchronizer runs regardless of en.
- en=0:
  - State, gate counter, period counter, edge counter and outputs hold; done is not asserted.
  - rise events occurring while en=0 are lost.
  - start is ignored while en=0.
- FSM IDLE:
  - busy=0.
  - If en & start: clear the working edge counter, period counter and gate counter; go to ARM.
- FSM ARM:
  - Gate counter counts up each cycle.
  - On rise: reset the gate counter and period counter to 0, clear edge count to 0 (the arming edge is not counted), go to MEASURE.
  - If the gate counter reaches GATE_CYCLES-1 with no rise: go to DONE with result freq=0, period=0, ovf=0, nosig=1.
- FSM MEASURE:
  - Gate counter increments each cycle; window = the GATE_CYCLES cycles after the arming edge.
  - On each rise within the window: edge count +1 (saturating at 2^CNT_W-1, setting the ovf flag); last_period <= period counter + 1; period counter <= 0.
  - Otherwise the period counter +1, saturating at 2^PER_W-1 and setting ovf.
  - A rise on the final window cycle is counted.
  - After GATE_CYCLES cycles: go to DONE.
- FSM DONE (one cycle):
  - freq, period, ovf and nosig load the working values; done=1; next state IDLE.
  - period = last_period if at least one edge was counted, else 0. nosig=0.
- Output timing and handshake:
  - Outputs change only in the DONE cycle or on reset.
  - start during busy is ignored.
  - start held high continuously re-triggers from IDLE, giving back-to-back measurements with a 1-cycle IDLE gap.
- Counter widths:
  - Gate counter width = clog2(GATE_CYCLES)+1.
  - No wrap-around on any counter; all saturate.

Test Plan (GATE_CYCLES=100, CNT_W=8, PER_W=8 unless noted):
1. Reset: drive rst=0 mid-sim while sig_in toggles → all outputs 0 immediately (same timestep); after rst=1, outputs stay 0 with no done until start.
2. sig_in period 10 cycles (5 high/5 low), pulse start → busy=1; after the arming edge, exactly 100 cycles then DONE; freq=10, period=10, ovf=0, nosig=0, done high 1 cycle, busy falls next cycle.
3. sig_in held 0, pulse start → done after 100 ARM cycles; freq=0, period=0, nosig=1.
4. Period-10 signal with en=0 for 20 cycles mid-MEASURE, sig_in held constant during the pause → done delayed by exactly 20 cycles; freq=10, period=10.
5. CNT_W=3, sig_in period 4 → freq=7, ovf=1. Separately, PER_W=4 with sig_in period 40 → period=15, ovf=1.
6. Async reset mid-MEASURE → no done, busy=0. Then pulse start while busy in a fresh run → ignored, result unaffected. start held high → second done exactly 1 IDLE cycle plus arm wait after the first.
